// File: rtl/keygen_pkg.sv
// Shared definitions for the PUF key-generation sequencer: FSM state
// encoding, result status codes and command mode codes.
package keygen_pkg;

    typedef enum logic [3:0] {
        IDLE,
        MLT_REQ,
        MLT_WAIT,
        MLT_ACK,
        PUF_REQ,
        PUF_WAIT,
        PUF_ACK,
        GJ_REQ,
        GJ_WAIT,
        GJ_ACK,
        CHK_REQ,
        CHK_WAIT,
        CHK_ACK,
        DONE
    } state_t;

    localparam logic [1:0] ST_OK         = 2'd0;
    localparam logic [1:0] ST_CHECK_FAIL = 2'd1;
    localparam logic [1:0] ST_TIMEOUT    = 2'd2;

    localparam logic MODE_ENROLL = 1'b0;
    localparam logic MODE_RECON  = 1'b1;

    // True for the states in which the sequencer is waiting on a unit.
    function automatic logic is_unit_wait(input state_t s);
        return (s == MLT_REQ) || (s == MLT_WAIT) ||
               (s == PUF_REQ) || (s == PUF_WAIT) ||
               (s == GJ_REQ)  || (s == GJ_WAIT)  ||
               (s == CHK_REQ) || (s == CHK_WAIT);
    endfunction

endpackage

// File: rtl/keygen_popcnt.sv
// Hamming weight of a W-bit vector, purely combinational.
module keygen_popcnt
    import keygen_pkg::*;
#(
    parameter int W  = 256,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] cnt
);

    // Ripple sum of all bits; the caller registers the result.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/keygen_seq.sv
// Key-generation sequencer. Drives the matrix-multiply (mlt), PUF and
// Gauss-Jordan (gj) units through their request/response handshakes for
// ENROLL (secret -> helper) and RECONSTRUCT (helper -> secret + check).
// Optional watchdog: define KEYGEN_SEQ_TIMEOUT_EN to abort a flow whose unit
// stalls for 2**TMO_W-1 cycles with status TIMEOUT.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. cmd: accepted in IDLE only. Unit req: req_valid is held with a
// stable operand until req_ready is seen, then dropped. Unit res: res_valid is
// watched only after the request was accepted; res_ready answers with a single
// one-cycle pulse. Result: res_valid is held with stable data until res_ready.
module keygen_seq
    import keygen_pkg::*;
#(
    parameter int M      = 256,
    parameter int N      = 128,
    parameter int MAXERR = 16,
    parameter int TMO_W  = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_mode,
    input  logic [N-1:0] secret_in,
    input  logic [M-1:0] helper_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [1:0]   res_status,
    output logic [M-1:0] helper_out,
    output logic [N-1:0] secret_out,
    output logic [N-1:0] mlt_x,
    input  logic [M-1:0] mlt_out,
    output logic         mlt_req_valid,
    input  logic         mlt_req_ready,
    input  logic         mlt_res_valid,
    output logic         mlt_res_ready,
    input  logic [M-1:0] puf_e,
    output logic         puf_req_valid,
    input  logic         puf_req_ready,
    input  logic         puf_res_valid,
    output logic         puf_res_ready,
    output logic [M-1:0] gj_x,
    input  logic [N-1:0] gj_s,
    output logic         gj_req_valid,
    input  logic         gj_req_ready,
    input  logic         gj_res_valid,
    output logic         gj_res_ready,
    output state_t       state_dbg
);

    localparam int PW = $clog2(M + 1);
    localparam logic [PW-1:0] MAXERR_C = PW'(MAXERR);

    state_t        state;
    logic          mode_q;
    logic [M-1:0]  b_q;     // enroll: mlt result, then helper after PUF
    logic [M-1:0]  v_q;     // reconstruct: helper, then helper ^ e
    logic [N-1:0]  s_q;     // reconstruct: solver result
    logic [M-1:0]  chk_q;   // reconstruct: A*s ^ v
    logic [PW-1:0] chk_cnt;

    assign state_dbg = state;

    keygen_popcnt #(.W(M), .CW(PW)) u_popcnt (
        .vec (chk_q),
        .cnt (chk_cnt)
    );

`ifdef KEYGEN_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    state_t           tmo_state;
    logic             tmo_hit;

    assign tmo_hit = is_unit_wait(state) && (state == tmo_state) && (tmo_cnt == '1);

    // Watchdog restarts whenever the FSM changes state, counts while it waits on a unit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            tmo_state <= IDLE;
        end else begin
            tmo_state <= state;
            if (state != tmo_state) begin
                tmo_cnt <= '0;
            end else if (is_unit_wait(state)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    logic tmo_w_unused;
    assign tmo_w_unused = (TMO_W > 0);
`endif

    // Main sequencer: every output is registered and updated on state transitions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            mode_q        <= MODE_ENROLL;
            cmd_ready     <= 1'b0;
            res_valid     <= 1'b0;
            res_status    <= ST_OK;
            helper_out    <= '0;
            secret_out    <= '0;
            mlt_x         <= '0;
            gj_x          <= '0;
            mlt_req_valid <= 1'b0;
            mlt_res_ready <= 1'b0;
            puf_req_valid <= 1'b0;
            puf_res_ready <= 1'b0;
            gj_req_valid  <= 1'b0;
            gj_res_ready  <= 1'b0;
            b_q           <= '0;
            v_q           <= '0;
            s_q           <= '0;
            chk_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        mode_q     <= cmd_mode;
                        res_status <= ST_OK;
                        helper_out <= '0;
                        secret_out <= '0;
                        if (cmd_mode == MODE_ENROLL) begin
                            mlt_x         <= secret_in;
                            mlt_req_valid <= 1'b1;
                            state         <= MLT_REQ;
                        end else begin
                            v_q           <= helper_in;
                            puf_req_valid <= 1'b1;
                            state         <= PUF_REQ;
                        end
                    end
                end
                MLT_REQ: begin
                    if (mlt_req_ready) begin
                        mlt_req_valid <= 1'b0;
                        state         <= MLT_WAIT;
                    end
                end
                MLT_WAIT: begin
                    if (mlt_res_valid) begin
                        b_q           <= mlt_out;
                        mlt_res_ready <= 1'b1;
                        state         <= MLT_ACK;
                    end
                end
                MLT_ACK: begin
                    mlt_res_ready <= 1'b0;
                    puf_req_valid <= 1'b1;
                    state         <= PUF_REQ;
                end
                PUF_REQ: begin
                    if (puf_req_ready) begin
                        puf_req_valid <= 1'b0;
                        state         <= PUF_WAIT;
                    end
                end
                PUF_WAIT: begin
                    if (puf_res_valid) begin
                        if (mode_q == MODE_ENROLL) begin
                            b_q <= b_q ^ puf_e;
                        end else begin
                            v_q <= v_q ^ puf_e;
                        end
                        puf_res_ready <= 1'b1;
                        state         <= PUF_ACK;
                    end
                end
                PUF_ACK: begin
                    puf_res_ready <= 1'b0;
                    if (mode_q == MODE_ENROLL) begin
                        helper_out <= b_q;
                        res_status <= ST_OK;
                        res_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        gj_x         <= v_q;
                        gj_req_valid <= 1'b1;
                        state        <= GJ_REQ;
                    end
                end
                GJ_REQ: begin
                    if (gj_req_ready) begin
                        gj_req_valid <= 1'b0;
                        state        <= GJ_WAIT;
                    end
                end
                GJ_WAIT: begin
                    if (gj_res_valid) begin
                        s_q          <= gj_s;
                        gj_res_ready <= 1'b1;
                        state        <= GJ_ACK;
                    end
                end
                GJ_ACK: begin
                    gj_res_ready  <= 1'b0;
                    mlt_x         <= s_q;
                    mlt_req_valid <= 1'b1;
                    state         <= CHK_REQ;
                end
                CHK_REQ: begin
                    if (mlt_req_ready) begin
                        mlt_req_valid <= 1'b0;
                        state         <= CHK_WAIT;
                    end
                end
                CHK_WAIT: begin
                    if (mlt_res_valid) begin
                        chk_q         <= mlt_out ^ v_q;
                        mlt_res_ready <= 1'b1;
                        state         <= CHK_ACK;
                    end
                end
                CHK_ACK: begin
                    // A recovered secret is only released if A*s lands close to v.
                    mlt_res_ready <= 1'b0;
                    res_valid     <= 1'b1;
                    state         <= DONE;
                    if (chk_cnt <= MAXERR_C) begin
                        res_status <= ST_OK;
                        secret_out <= s_q;
                    end else begin
                        res_status <= ST_CHECK_FAIL;
                        secret_out <= '0;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef KEYGEN_SEQ_TIMEOUT_EN
            // A stalled unit aborts the flow; this overrides whatever the case chose.
            if (tmo_hit) begin
                mlt_req_valid <= 1'b0;
                mlt_res_ready <= 1'b0;
                puf_req_valid <= 1'b0;
                puf_res_ready <= 1'b0;
                gj_req_valid  <= 1'b0;
                gj_res_ready  <= 1'b0;
                helper_out    <= '0;
                secret_out    <= '0;
                mlt_x         <= '0;
                gj_x          <= '0;
                res_status    <= ST_TIMEOUT;
                res_valid     <= 1'b1;
                state         <= DONE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_keygen_seq.sv
// Self-checking bench for keygen_seq. Unit stubs: mlt returns {x,x}, PUF
// returns a bench-chosen error vector, gj returns a bench-chosen secret.
module tb_keygen_seq;
    import keygen_pkg::*;

    localparam int M      = 256;
    localparam int N      = 128;
    localparam int MAXERR = 16;
    localparam int TMO_W  = 4;

    localparam logic [N-1:0] KEY = 128'h139871fcaa59a6eab6afb399292871e9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         cmd_valid, cmd_ready, cmd_mode;
    logic [N-1:0] secret_in;
    logic [M-1:0] helper_in;
    logic         res_valid, res_ready;
    logic [1:0]   res_status;
    logic [M-1:0] helper_out;
    logic [N-1:0] secret_out;
    logic [N-1:0] mlt_x;
    logic [M-1:0] mlt_out;
    logic [M-1:0] puf_e;
    logic [M-1:0] gj_x;
    logic [N-1:0] gj_s;
    state_t       state_dbg;

    // unit index: 0 = mlt, 1 = puf, 2 = gj
    logic u_req_valid[3];
    logic u_req_ready[3];
    logic u_res_valid[3];
    logic u_res_ready[3];

    keygen_seq #(.M(M), .N(N), .MAXERR(MAXERR), .TMO_W(TMO_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .secret_in     (secret_in),
        .helper_in     (helper_in),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_status    (res_status),
        .helper_out    (helper_out),
        .secret_out    (secret_out),
        .mlt_x         (mlt_x),
        .mlt_out       (mlt_out),
        .mlt_req_valid (u_req_valid[0]),
        .mlt_req_ready (u_req_ready[0]),
        .mlt_res_valid (u_res_valid[0]),
        .mlt_res_ready (u_res_ready[0]),
        .puf_e         (puf_e),
        .puf_req_valid (u_req_valid[1]),
        .puf_req_ready (u_req_ready[1]),
        .puf_res_valid (u_res_valid[1]),
        .puf_res_ready (u_res_ready[1]),
        .gj_x          (gj_x),
        .gj_s          (gj_s),
        .gj_req_valid  (u_req_valid[2]),
        .gj_req_ready  (u_req_ready[2]),
        .gj_res_valid  (u_res_valid[2]),
        .gj_res_ready  (u_res_ready[2]),
        .state_dbg     (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- unit stubs ----------------
    int           ph[3];
    int           cnt[3];
    int           wcnt[3];
    logic [N-1:0] mlt_op;
    logic [M-1:0] puf_cfg_e;
    logic [N-1:0] gj_cfg_s;
    bit           puf_never;
    int           rdy_max;
    int           res_max;
    int           hs_err;

    function automatic void grant(input int u);
        u_req_ready[u] = 1'b1;
        ph[u] = 2;
        if (u == 0) mlt_op = mlt_x;
    endfunction

    function automatic void present(input int u);
        u_res_valid[u] = 1'b1;
        ph[u] = 4;
        wcnt[u] = 0;
        case (u)
            0:       mlt_out = {mlt_op, mlt_op};
            1:       puf_e = puf_cfg_e;
            default: gj_s = gj_cfg_s;
        endcase
    endfunction

    // One negedge step of a unit: random ready delay, random result delay,
    // and protocol observations (req_valid drop, single res_ready pulse).
    function automatic void step_unit(input int u);
        if (!rst) begin
            ph[u] = 0;
            u_req_ready[u] = 1'b0;
            u_res_valid[u] = 1'b0;
            return;
        end
        case (ph[u])
            0: if (u_req_valid[u]) begin
                cnt[u] = $urandom_range(0, rdy_max);
                if (cnt[u] == 0) grant(u); else ph[u] = 1;
            end
            1: begin
                cnt[u]--;
                if (cnt[u] <= 0) grant(u);
            end
            2: begin
                u_req_ready[u] = 1'b0;
                if (u_req_valid[u] !== 1'b0) hs_err++;
                if (u == 1 && puf_never) begin
                    ph[u] = 6;
                end else begin
                    cnt[u] = $urandom_range(0, res_max);
                    if (cnt[u] == 0) present(u); else ph[u] = 3;
                end
            end
            3: begin
                cnt[u]--;
                if (cnt[u] <= 0) present(u);
            end
            4: if (u_res_ready[u] === 1'b1) begin
                ph[u] = 5;
            end else begin
                wcnt[u]++;
                if (wcnt[u] > 4000) begin
                    hs_err++;
                    u_res_valid[u] = 1'b0;
                    ph[u] = 0;
                end
            end
            5: begin
                u_res_valid[u] = 1'b0;
                if (u_res_ready[u] !== 1'b0) hs_err++;
                ph[u] = 0;
            end
            default: ;
        endcase
    endfunction

    initial begin : unit_stubs
        hs_err = 0;
        for (int u = 0; u < 3; u++) begin
            ph[u] = 0;
            cnt[u] = 0;
            wcnt[u] = 0;
            u_req_ready[u] = 1'b0;
            u_res_valid[u] = 1'b0;
        end
        mlt_out = '0;
        puf_e = '0;
        gj_s = '0;
        mlt_op = '0;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) step_unit(u);
        end
    end

    // Transfer counters observed at the active edge.
    int done_cnt = 0;
    int mlt_acc  = 0;
    always @(posedge clk) begin
        if (rst && res_valid && res_ready) done_cnt <= done_cnt + 1;
        if (rst && u_req_valid[0] && u_req_ready[0]) mlt_acc <= mlt_acc + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [M-1:0] model_enroll(input logic [N-1:0] s, input logic [M-1:0] e);
        return {s, s} ^ e;
    endfunction

    // returns {status, secret}
    function automatic logic [N+1:0] model_recon(input logic [M-1:0] h, input logic [M-1:0] e,
                                                 input logic [N-1:0] s_gj);
        logic [M-1:0] v;
        int d;
        v = h ^ e;
        d = $countones({s_gj, s_gj} ^ v);
        if (d <= MAXERR) return {ST_OK, s_gj};
        return {ST_CHECK_FAIL, {N{1'b0}}};
    endfunction

    function automatic logic [M-1:0] sparse(input int k);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < k; i++) r[$urandom_range(0, M - 1)] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic mode, input logic [N-1:0] s, input logic [M-1:0] h,
                           output bit got, output logic [1:0] st,
                           output logic [M-1:0] ho, output logic [N-1:0] so);
        got = 1'b0;
        st = '0;
        ho = '0;
        so = '0;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_mode = mode;
        secret_in = s;
        helper_in = h;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3000 && !res_valid; i++) @(negedge clk);
        if (!res_valid) return;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        st = res_status;
        ho = helper_out;
        so = secret_out;
        got = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [2+M-1:0] exp_q[$];

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [M+N+N+M+9:0] outs;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        outs = {cmd_ready, res_valid, res_status, helper_out, secret_out, mlt_x, gj_x,
                u_req_valid[0], u_res_ready[0], u_req_valid[1], u_res_ready[1]};
        n_checks++;
        if (outs !== '0 || u_req_valid[2] !== 1'b0 || u_res_ready[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero in reset (cmd_ready=%b res_valid=%b status=%0d)",
                     cmd_ready, res_valid, res_status);
        end
        n_checks++;
        if (state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_enroll();
        bit got;
        logic [1:0] st;
        logic [M-1:0] ho;
        logic [N-1:0] so;
        int d0;
        rdy_max = 0;
        res_max = 0;
        puf_cfg_e = '0;
        d0 = done_cnt;
        run_cmd(MODE_ENROLL, KEY, '0, got, st, ho, so);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL enroll_done: no result within cycle budget");
        end
        n_checks++;
        if (ho !== {KEY, KEY}) begin
            n_fail++;
            $display("FAIL enroll_helper: got %h want %h", ho, {KEY, KEY});
        end
        n_checks++;
        if (st !== ST_OK) begin
            n_fail++;
            $display("FAIL enroll_status: got %0d want 0", st);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enroll_once: got %0d results res_valid=%b want 1 result", done_cnt - d0, res_valid);
        end
    endtask

    task automatic test_reconstruct();
        bit got;
        logic [1:0] st;
        logic [M-1:0] ho;
        logic [N-1:0] so;
        int m0;
        puf_cfg_e = '0;
        gj_cfg_s = KEY;
        m0 = mlt_acc;
        run_cmd(MODE_RECON, '0, {KEY, KEY}, got, st, ho, so);
        n_checks++;
        if (!got || so !== KEY) begin
            n_fail++;
            $display("FAIL recon_secret: got %h want %h (done=%0d)", so, KEY, got);
        end
        n_checks++;
        if (st !== ST_OK) begin
            n_fail++;
            $display("FAIL recon_status: got %0d want 0", st);
        end
        n_checks++;
        if (mlt_acc - m0 !== 1) begin
            n_fail++;
            $display("FAIL recon_mlt_requests: got %0d want 1", mlt_acc - m0);
        end
    endtask

    task automatic test_check_boundary();
        bit got;
        logic [1:0] st;
        logic [M-1:0] ho;
        logic [N-1:0] so;
        logic [N-1:0] bad;
        // 8 flipped secret bits -> 16 mismatches in {s,s}: accepted
        bad = KEY ^ 128'hff;
        gj_cfg_s = bad;
        puf_cfg_e = '0;
        run_cmd(MODE_RECON, '0, {KEY, KEY}, got, st, ho, so);
        n_checks++;
        if (!got || st !== ST_OK || so !== bad) begin
            n_fail++;
            $display("FAIL check_d16: status %0d secret %h want status 0 secret %h", st, so, bad);
        end
        // one more PUF error bit -> 17 mismatches: rejected
        puf_cfg_e = '0;
        puf_cfg_e[200] = 1'b1;
        run_cmd(MODE_RECON, '0, {KEY, KEY}, got, st, ho, so);
        n_checks++;
        if (!got || st !== ST_CHECK_FAIL) begin
            n_fail++;
            $display("FAIL check_d17_status: got %0d want 1", st);
        end
        n_checks++;
        if (so !== '0) begin
            n_fail++;
            $display("FAIL check_d17_secret: got %h want 0", so);
        end
        puf_cfg_e = '0;
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [1:0] st;
        logic [M-1:0] ho;
        logic [N-1:0] so;
        logic [2+M-1:0] exp;
        logic [N+1:0] r;
        logic [N-1:0] s;
        logic [M-1:0] h;
        logic mode;
        int e0;
        rdy_max = 5;
        res_max = 50;
        e0 = hs_err;
        for (int it = 0; it < 20; it++) begin
            mode = 1'($urandom_range(0, 1));
            s = rand_key();
            puf_cfg_e = sparse($urandom_range(0, 10));
            if (mode == MODE_ENROLL) begin
                h = '0;
                exp_q.push_back({ST_OK, model_enroll(s, puf_cfg_e)});
            end else begin
                h = {s, s} ^ sparse($urandom_range(0, 4));
                gj_cfg_s = s ^ sparse($urandom_range(0, 5))[N-1:0];
                r = model_recon(h, puf_cfg_e, gj_cfg_s);
                exp_q.push_back({r[N+1:N], {(M-N){1'b0}}, r[N-1:0]});
            end
            run_cmd(mode, s, h, got, st, ho, so);
            exp = exp_q.pop_front();
            n_checks++;
            if (!got || st !== exp[M+1:M]) begin
                n_fail++;
                $display("FAIL stress_status[%0d]: got %0d want %0d (done=%0d)", it, st, exp[M+1:M], got);
            end
            n_checks++;
            if (mode == MODE_ENROLL ? (ho !== exp[M-1:0]) : (so !== exp[N-1:0])) begin
                n_fail++;
                $display("FAIL stress_data[%0d]: mode %0d helper %h secret %h want %h",
                         it, mode, ho, so, exp[M-1:0]);
            end
        end
        n_checks++;
        if (hs_err - e0 !== 0) begin
            n_fail++;
            $display("FAIL stress_handshake: got %0d protocol violations want 0", hs_err - e0);
        end
        rdy_max = 0;
        res_max = 0;
    endtask

    task automatic test_reset_mid_flow();
        bit got;
        logic [1:0] st;
        logic [M-1:0] ho;
        logic [N-1:0] so;
        logic [N-1:0] s;
        puf_never = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode = MODE_ENROLL;
        secret_in = KEY;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && state_dbg != PUF_WAIT; i++) @(negedge clk);
        n_checks++;
        if (state_dbg !== PUF_WAIT) begin
            n_fail++;
            $display("FAIL midrst_reach: got state %0d want %0d", state_dbg, PUF_WAIT);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, res_valid, res_status, helper_out, secret_out, mlt_x, gj_x} !== '0 ||
            u_req_valid[1] !== 1'b0 || u_res_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: cmd_ready=%b res_valid=%b puf_req_valid=%b want all 0",
                     cmd_ready, res_valid, u_req_valid[1]);
        end
        @(negedge clk);
        rst = 1'b1;
        puf_never = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready);
        end
        s = rand_key();
        puf_cfg_e = sparse(3);
        run_cmd(MODE_ENROLL, s, '0, got, st, ho, so);
        n_checks++;
        if (!got || st !== ST_OK || ho !== model_enroll(s, puf_cfg_e)) begin
            n_fail++;
            $display("FAIL midrst_enroll: status %0d helper %h want %h", st, ho, model_enroll(s, puf_cfg_e));
        end
    endtask

    task automatic test_timeout();
`ifdef KEYGEN_SEQ_TIMEOUT_EN
        bit got;
        logic [1:0] st;
        logic [M-1:0] ho;
        logic [N-1:0] so;
        puf_never = 1'b1;
        run_cmd(MODE_RECON, '0, {KEY, KEY}, got, st, ho, so);
        n_checks++;
        if (!got || st !== ST_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_status: got %0d want 2 (done=%0d)", st, got);
        end
        n_checks++;
        if (ho !== '0 || so !== '0) begin
            n_fail++;
            $display("FAIL timeout_data: helper %h secret %h want 0", ho, so);
        end
`else
        bit seen;
        puf_never = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode = MODE_ENROLL;
        secret_in = KEY;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_wait: res_valid rose, want it held 0 for 1000 cycles");
        end
`endif
        apply_reset();
        puf_never = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin : main
        cmd_valid = 1'b0;
        cmd_mode = 1'b0;
        secret_in = '0;
        helper_in = '0;
        res_ready = 1'b0;
        puf_cfg_e = '0;
        gj_cfg_s = '0;
        puf_never = 1'b0;
        rdy_max = 0;
        res_max = 0;
        test_reset();
        test_enroll();
        test_reconstruct();
        test_check_boundary();
        test_back_to_back();
        test_reset_mid_flow();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL global_timeout: simulation exceeded time limit, checks so far %0d", n_checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/keygen_seq.md
Name: keygen_seq

Overview:
Parametrised key-generation sequencer for the PUF-based device key. It drives the matrix-multiply, ring-oscillator PUF and Gauss-Jordan solver units over their req/res handshakes and supports two modes:
- ENROLL: secret -> public helper.
- RECONSTRUCT: helper -> secret, with a consistency check.

It replaces hand-written per-flow control and sits between the host command interface and the three arithmetic units.

Parameters:
M, 256, helper/PUF vector width (matrix rows)
N, 128, secret width (matrix columns)
MAXERR, 16, max Hamming distance accepted by the reconstruct check
TMO_W, 20, width of the per-unit watchdog counter (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
cmd_mode  in  1  0=ENROLL, 1=RECONSTRUCT
secret_in  in  N  secret for ENROLL
helper_in  in  M  helper for RECONSTRUCT
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_status  out  2  0=OK, 1=CHECK_FAIL, 2=TIMEOUT
helper_out  out  M  ENROLL result (b ^ e)
secret_out  out  N  RECONSTRUCT result
mlt_x  out  N  matmlt operand
mlt_out  in  M  matmlt result
mlt_req_valid/mlt_req_ready/mlt_res_valid/mlt_res_ready  out/in/in/out  1 each  matmlt handshake
puf_e  in  M  PUF response
puf_req_valid/puf_req_ready/puf_res_valid/puf_res_ready  out/in/in/out  1 each  PUF handshake
gj_x  out  M  solver operand
gj_s  in  N  solver result
gj_req_valid/gj_req_ready/gj_res_valid/gj_res_ready  out/in/in/out  1 each  solver handshake

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE.
  - All req_valid, res_ready and res_valid are 0; res_status is 0.
  - All data outputs are 0.
  - Reset mid-operation abandons the flow. Unit handshakes drop the next cycle.
- Command accept: cmd_valid && cmd_ready at a posedge captures mode and operands, then leaves IDLE.
- Unit handshake, identical for all three units. Each unit uses three states: X_REQ, X_WAIT, X_ACK.
  - X_REQ: req_valid=1 with the operand registered. Move to X_WAIT on the cycle req_ready is sampled high. req_valid drops on entry to X_WAIT.
  - X_WAIT: on res_valid, capture the unit data and go to X_ACK.
  - X_ACK: res_ready=1 for exactly one cycle.
- ENROLL path:
  - MLT: mlt_x=secret; b=mlt_out.
  - PUF: h = b ^ puf_e.
  - DONE: helper_out=h, status OK.
- RECONSTRUCT path:
  - PUF: v = helper ^ puf_e.
  - GJ: gj_x=v; s=gj_s.
  - CHK: mlt_x=s; d = popcount(mlt_out ^ v).
  - DONE: secret_out=s. status is OK if d<=MAXERR, otherwise CHECK_FAIL. On CHECK_FAIL, secret_out is forced to 0.
- DONE:
  - res_valid=1, held until res_ready; then return to IDLE.
  - res_valid and res_ready in the same cycle completes that cycle.
  - cmd_ready=0 outside IDLE; cmd_valid is ignored there.
- Latency: command-to-result cycles = sum of unit latencies + 3 cycles per unit + 2.
- Popcount is combinational over M bits, registered in CHK_ACK. MAXERR compares as unsigned at clog2(M+1) bits.
- Units returning res_valid before the corresponding req is accepted are ignored (X_REQ does not look at res_valid).

Optional Feature:
KEYGEN_SEQ_TIMEOUT_EN
- Defined:
  - A TMO_W-bit counter clears on entry to each X_REQ/X_WAIT state and increments every cycle there.
  - At all-ones, the sequencer drops req_valid and goes straight to DONE with status TIMEOUT and zeroed data outputs.
- Undefined:
  - No counter; the sequencer waits indefinitely; status 2 is never produced.

Decomposition:
- Shared package keygen_pkg holds:
  - state enum (IDLE, MLT_REQ/WAIT/ACK, PUF_REQ/WAIT/ACK, GJ_REQ/WAIT/ACK, CHK_REQ/WAIT/ACK, DONE);
  - status constants ST_OK=0, ST_CHECK_FAIL=1, ST_TIMEOUT=2;
  - mode constants MODE_ENROLL=0, MODE_RECON=1.
- Sub-module keygen_popcnt (param W) produces the Hamming weight; the FSM stays in keygen_seq.

Test Plan:
- Enroll with secret_in=128'h139871fcaa59a6eab6afb399292871e9, matmlt stub b=secret replicated twice, PUF stub e=256'h0 -> helper_out equals the replicated secret, status 0, res_valid exactly once.
- Reconstruct with that helper, PUF e=0, gj stub returns the true secret -> secret_out=128'h1398...71e9, status 0; CHK issues exactly one mlt request.
- Reconstruct with the gj stub returning a corrupted secret such that popcount=17 -> status 1, secret_out=0; with popcount=16 -> status 0.
- Handshake stress: req_ready delayed 0..5 cycles and res_valid delayed 0..50 -> each req_valid drops one cycle after acceptance, each res_ready is a single-cycle pulse, results unchanged.
- Drive rst=0 during PUF_WAIT, then rst=1 -> all outputs 0, cmd_ready=1 next cycle; a fresh enroll completes correctly.
- With KEYGEN_SEQ_TIMEOUT_EN and TMO_W=4, PUF never asserts res_valid -> status 2 after 15 wait cycles. Without the macro, res_valid stays 0 for 1000 cycles.
